hdr_field_sched: RTL and testbench
==================================

Name: hdr_field_sched

Overview:
- Programmable header-field capture scheduler.
- Starts on the IPv4 start pulse from the upstream ethertype finder.
- Captures up to N_FIELDS configured fields from the Avalon-ST beat stream, then drains them one per cycle over a valid/ready output in ascending entry order.
- Replaces the per-field fixed extractors. Feeds the display/statistics logic downstream.

Parameters:
N_FIELDS, 4, number of capture table entries
MAX_WORD, 15, highest word index (relative to IPv4 word 0) an entry may target
CNT_W, 16, width of overrun/truncation counters

Ports:
sys_clk  in  1  clock
reset_n  in  1  async reset, active low
in  in  avln_st  monitored stream (data W bits, valid, sop, eop); observe only, never stalled
start  in  1  pulse; the beat present this cycle is IPv4 word 0
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(N_FIELDS)  entry index
cfg_en  in  1  entry enable
cfg_word  in  $clog2(MAX_WORD+1)  word index
cfg_offset  in  $clog2(W)  bit offset from MSB of word
cfg_width  in  $clog2(W)+1  field width, 1..W
cfg_err  out  1  one-cycle pulse: write rejected
out_valid  out  1  field available
out_ready  in  1  consumer accepts
out_id  out  $clog2(N_FIELDS)  entry index of field
out_data  out  W  field, right-aligned, zero-extended
out_last  out  1  final field of this header
busy  out  1  FSM not IDLE
overrun_cnt  out  CNT_W  saturating count of starts that discarded pending work
trunc_cnt  out  CNT_W  saturating count of scans ended with enabled entries uncaptured

Behaviour:
- Reset: all outputs 0, table entries disabled, FSM IDLE, pending/captured masks 0.
- Config write:
  - Applied the cycle after cfg_we.
  - Rejected (table unchanged, cfg_err=1 next cycle) if cfg_width==0, offset+width>W, or cfg_word>MAX_WORD.
  - Writes are accepted in any state. The active table is a snapshot taken at start, so writes take effect at the next start.
- Extraction: field = in.data[W-1-offset -: width], zero-extended to W.
- Word counter:
  - On start, the counter is 0 for the current beat.
  - It increments on every in.valid beat while in SCAN.
  - Beats with in.valid=0 do not count and capture nothing.
- FSM IDLE:
  - start with ≥1 enabled entry → SCAN: snapshot the table; the start beat is word 0 and is compared that same cycle.
  - start with no enabled entries is ignored.
- FSM SCAN:
  - Each valid beat is compared against all uncaptured enabled entries in parallel. Every match is captured into its holding register, and its pending and captured bits are set next cycle.
  - → DRAIN when all enabled entries are captured, or on in.valid&in.eop, or on a valid beat with counter==MAX_WORD.
  - in.sop while in SCAN (without start) → DRAIN.
  - Any exit with uncaptured enabled entries increments trunc_cnt.
- FSM DRAIN: pending==0 → IDLE.
- Output:
  - Drain starts in SCAN as soon as anything is pending.
  - out_valid=1 when pending≠0. out_id is the lowest pending index; out_data is its register.
  - On out_valid&out_ready the pending bit clears the next cycle, and the next entry may be presented then.
  - Rate is one field per cycle; minimum capture-to-out_valid latency is 1 cycle.
  - out_data/out_id are held stable while out_valid&!out_ready.
  - out_last=1 when the FSM is in DRAIN and exactly one pending bit is set.
  - If a scan ends with nothing pending, no out_last is produced.
- start while in SCAN or DRAIN:
  - If pending≠0, all pending bits are discarded and overrun_cnt increments; a start with pending==0 does not count.
  - The new snapshot is taken and the FSM enters SCAN. The current beat is word 0 of the new header.
  - start takes priority over eop/sop/completion in the same cycle.
- Counters saturate at all-ones.
- Reset mid-operation returns everything to reset values immediately; the table is cleared.

Decomposition:
- global_types provides W, B, BpW, avln_st, max().
- Add to global_types a typedef fld_cfg_t {en, word, offset, width} and a typedef sched_state_t {IDLE, SCAN, DRAIN}.
- Sub-module pri_pick: a lowest-set-bit priority encoder (one-hot mask → index + any). It is reused for the output selection.

Test Plan:
- Setup: W=32; entry0={1,1,0,16}, entry1={1,1,16,3}, entry2={1,2,8,8}.
- Basic capture: start with words 0x45000054, 0x1C464000, 0x4006B1E6, out_ready=1 → (id0,0x1C46), (id1,0x2), (id2,0x06,last=1); trunc_cnt=0, IDLE after.
- Backpressure: same stream, out_ready=0 for 10 cycles → out_valid high, id0/0x1C46 held stable; release → three fields in order on consecutive cycles.
- Truncation: in.eop on word 1 → id0 and id1 emitted, no out_last, trunc_cnt=1.
- Overrun: second start 1 cycle after word 2 with out_ready=0 → overrun_cnt=1; only the second header's fields appear.
- Config: cfg_width=20, offset=16 → cfg_err pulse, entry unchanged. A write during SCAN has no effect until the next start.
- Stalls/reset: in.valid gaps between words → same outputs as basic. reset_n low mid-SCAN → all outputs 0, busy=0.

Source files
------------

// File: rtl/hdr_field_sched_pkg.sv
// Shared types for the header-field capture scheduler: stream beat, capture entry, FSM state.
package hdr_field_sched_pkg;

  localparam int unsigned W      = 32;
  localparam int unsigned B      = 8;
  localparam int unsigned BpW    = W / B;
  // Entry word field is sized for any MAX_WORD up to 255.
  localparam int unsigned WORD_W = 8;
  localparam int unsigned OFF_W  = $clog2(W);
  localparam int unsigned WID_W  = $clog2(W) + 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
    logic         sop;
    logic         eop;
  } avln_st;

  typedef struct packed {
    logic              en;
    logic [WORD_W-1:0] word;
    logic [OFF_W-1:0]  offset;
    logic [WID_W-1:0]  width;
  } fld_cfg_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} sched_state_t;

  function automatic int unsigned max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // MSB-relative field, right-aligned and zero-extended.
  function automatic logic [W-1:0] extract(logic [W-1:0] d, logic [OFF_W-1:0] off,
                                           logic [WID_W-1:0] wid);
    logic [W-1:0] t;
    t = d << off;
    return t >> (WID_W'(W) - wid);
  endfunction

endpackage

// File: rtl/hdr_field_sched_pri_pick.sv
// Lowest-set-bit priority encoder: mask to index plus any-set flag.
module hdr_field_sched_pri_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdr_field_sched.sv
// Programmable header-field capture scheduler: snapshots a capture table on start, grabs
// configured fields from the beat stream and drains them in ascending entry order.
module hdr_field_sched
  import hdr_field_sched_pkg::*;
#(
  parameter int unsigned N_FIELDS = 4,
  parameter int unsigned MAX_WORD = 15,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = max(1, $clog2(N_FIELDS)),
  localparam int unsigned CW_W    = $clog2(MAX_WORD + 1)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  avln_st           in,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic             cfg_en,
  input  logic [CW_W-1:0]  cfg_word,
  input  logic [OFF_W-1:0] cfg_offset,
  input  logic [WID_W-1:0] cfg_width,
  output logic             cfg_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_id,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] trunc_cnt
);

  fld_cfg_t          tbl_q  [N_FIELDS];
  fld_cfg_t          snap_q [N_FIELDS];
  logic [W-1:0]      hold_q [N_FIELDS];
  logic [N_FIELDS-1:0] pend_q, capt_q;
  logic [WORD_W-1:0] cnt_q;
  sched_state_t      state_q;
  logic              trunc_q;
  logic              cfg_err_q;
  logic [CNT_W-1:0]  overrun_q, trunc_cnt_q;

  fld_cfg_t            cur_snap [N_FIELDS];
  logic [N_FIELDS-1:0] en_m, match, cur_capt, capt_d, left_m, old_left, pop_m, pend_d;
  logic [WORD_W-1:0]   cur_word;
  logic                scanning, scan_end, cfg_bad, restart;

  assign cfg_bad = (cfg_width == '0) ||
                   ((7'(cfg_offset) + 7'(cfg_width)) > 7'(W)) ||
                   (32'(cfg_word) > MAX_WORD);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_FIELDS; i++) tbl_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && cfg_bad;
      if (cfg_we && !cfg_bad) begin
        tbl_q[cfg_addr] <= '{en: cfg_en, word: WORD_W'(cfg_word), offset: cfg_offset,
                             width: cfg_width};
      end
    end
  end

  hdr_field_sched_pri_pick #(
    .N  (N_FIELDS),
    .IW (IDX_W)
  ) u_out_pick (
    .mask (pend_q),
    .idx  (out_id),
    .any  (out_valid)
  );

  // On a start cycle the fresh table and word 0 are evaluated against the current beat.
  always_comb begin
    for (int i = 0; i < N_FIELDS; i++) begin
      cur_snap[i] = start ? tbl_q[i] : snap_q[i];
      en_m[i]     = cur_snap[i].en;
      old_left[i] = snap_q[i].en && !capt_q[i];
    end
    cur_word = start ? '0 : cnt_q;
    cur_capt = start ? '0 : capt_q;
    scanning = start ? (|en_m) : (state_q == SCAN);
    for (int i = 0; i < N_FIELDS; i++) begin
      match[i] = scanning && in.valid && en_m[i] && !cur_capt[i] &&
                 (cur_snap[i].word == cur_word);
    end
    capt_d   = cur_capt | match;
    left_m   = en_m & ~capt_d;
    pop_m    = '0;
    if (out_valid && out_ready) pop_m[out_id] = 1'b1;
    pend_d   = (start ? '0 : (pend_q & ~pop_m)) | match;
    scan_end = (left_m == '0) || in.sop ||
               (in.valid && (in.eop || (32'(cur_word) == MAX_WORD)));
    restart  = start && ((state_q != IDLE) || (|en_m));
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_FIELDS; i++) begin
        snap_q[i] <= '0;
        hold_q[i] <= '0;
      end
      pend_q      <= '0;
      capt_q      <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      trunc_q     <= 1'b0;
      overrun_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < N_FIELDS; i++) begin
        if (match[i]) hold_q[i] <= extract(in.data, cur_snap[i].offset, cur_snap[i].width);
      end
      if (restart) begin
        snap_q  <= tbl_q;
        capt_q  <= capt_d;
        cnt_q   <= in.valid ? WORD_W'(1) : '0;
        trunc_q <= 1'b0;
        state_q <= (|en_m) ? SCAN : DRAIN;
        if ((|pend_q) && (overrun_q != '1)) overrun_q <= overrun_q + 1'b1;
        if ((state_q == SCAN) && (|old_left) && (trunc_cnt_q != '1)) begin
          trunc_cnt_q <= trunc_cnt_q + 1'b1;
        end
      end else begin
        unique case (state_q)
          SCAN: begin
            capt_q <= capt_d;
            if (in.valid) cnt_q <= cnt_q + 1'b1;
            if (scan_end) begin
              state_q <= DRAIN;
              if (|left_m) begin
                trunc_q <= 1'b1;
                if (trunc_cnt_q != '1) trunc_cnt_q <= trunc_cnt_q + 1'b1;
              end
            end
          end
          DRAIN: if (pend_q == '0) state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  // A truncated header has no defined final field, so out_last stays low for it.
  assign out_last    = (state_q == DRAIN) && !trunc_q && (pend_q != '0) &&
                       ((pend_q & (pend_q - 1'b1)) == '0);
  assign out_data    = hold_q[out_id];
  assign busy        = (state_q != IDLE);
  assign cfg_err     = cfg_err_q;
  assign overrun_cnt = overrun_q;
  assign trunc_cnt   = trunc_cnt_q;

endmodule

// File: tb/tb_hdr_field_sched.sv
// Scoreboard bench for hdr_field_sched: directed headers push expected fields, a monitor pops.
module tb_hdr_field_sched;
  import hdr_field_sched_pkg::*;

  logic         sys_clk, reset_n, start, cfg_we, cfg_en, cfg_err;
  avln_st       in_s;
  logic [1:0]   cfg_addr, out_id;
  logic [3:0]   cfg_word;
  logic [4:0]   cfg_offset;
  logic [5:0]   cfg_width;
  logic         out_valid, out_ready, out_last, busy;
  logic [31:0]  out_data;
  logic [15:0]  overrun_cnt, trunc_cnt;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  hdr_field_sched dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .in          (in_s),
    .start       (start),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_en      (cfg_en),
    .cfg_word    (cfg_word),
    .cfg_offset  (cfg_offset),
    .cfg_width   (cfg_width),
    .cfg_err     (cfg_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .trunc_cnt   (trunc_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic v, input logic e, input logic st);
    in_s.data  = d;
    in_s.valid = v;
    in_s.sop   = 1'b0;
    in_s.eop   = e;
    start      = st;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) drive(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic cfg(input int a, input logic en, input int word, input int off, input int wid,
                     input logic exp_err);
    cfg_we     = 1'b1;
    cfg_addr   = 2'(a);
    cfg_en     = en;
    cfg_word   = 4'(word);
    cfg_offset = 5'(off);
    cfg_width  = 6'(wid);
    @(posedge sys_clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_err", {63'd0, cfg_err}, {63'd0, exp_err});
  endtask

  task automatic expect_f(input int id, input logic [31:0] d, input logic last);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic send3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                       input int gap, input logic eop1);
    drive(w0, 1'b1, 1'b0, 1'b1);
    gaps(gap);
    drive(w1, 1'b1, eop1, 1'b0);
    if (!eop1) begin
      gaps(gap);
      drive(w2, 1'b1, 1'b0, 1'b0);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else begin
        @(posedge sys_clk);
        #1;
      end
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic std_expect(input logic [31:0] f2);
    expect_f(0, 32'h1C46, 1'b0);
    expect_f(1, 32'h2, 1'b0);
    expect_f(2, f2, 1'b1);
  endtask

  initial begin
    logic       stall_prev;
    logic [1:0] held_id;
    logic [31:0] held_data;
    reset_n = 1'b0;
    out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_word = '0; cfg_offset = '0; cfg_width = '0;
    in_s = '0;
    start = 1'b0;
    stall_prev = 1'b0;
    held_id = '0;
    held_data = '0;

    fork
      forever begin
        exp_t e;
        @(negedge sys_clk);
        if (!reset_n) begin
          stall_prev = 1'b0;
        end else begin
          if (stall_prev && out_valid) begin
            check("hold_id", {62'd0, out_id}, {62'd0, held_id});
            check("hold_data", {32'd0, out_data}, {32'd0, held_data});
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_field", {30'd0, out_id, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("field_id", {62'd0, out_id}, {62'd0, e.id});
              check("field_data", {32'd0, out_data}, {32'd0, e.data});
              check("field_last", {63'd0, out_last}, {63'd0, e.last});
            end
          end
          stall_prev = out_valid && !out_ready;
          held_id    = out_id;
          held_data  = out_data;
        end
      end
    join_none

    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_flags", {60'd0, out_valid, busy, out_last, cfg_err}, 64'd0);
    check("reset_cnts", {32'd0, overrun_cnt, trunc_cnt}, 64'd0);
    reset_n = 1'b1;
    @(posedge sys_clk);
    #1;

    cfg(0, 1'b1, 1, 0, 16, 1'b0);
    cfg(1, 1'b1, 1, 16, 3, 1'b0);
    cfg(2, 1'b1, 2, 8, 8, 1'b0);

    // Basic capture.
    std_expect(32'h06);
    send3(32'h45000054, 32'h1C464000, 32'h4006B1E6, 0, 1'b0);
    wait_idle("basic_drain");
    check("basic_trunc", {48'd0, trunc_cnt}, 64'd0);

    // Backpressure, then three fields on consecutive cycles.
    out_ready = 1'b0;
    std_expect(32'h06);
    send3(32'h45000054, 32'h1C464000, 32'h4006B1E6, 0, 1'b0);
    repeat (10) @(posedge sys_clk);
    #1;
    check("bp_stall", {29'd0, out_valid, out_id, out_data}, {29'd0, 1'b1, 2'd0, 32'h1C46});
    out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("bp_consecutive", 64'(exp_q.size()), 64'd0);
    wait_idle("bp_drain");

    // Truncation by eop on word 1.
    expect_f(0, 32'h1C46, 1'b0);
    expect_f(1, 32'h2, 1'b0);
    send3(32'h45000054, 32'h1C464000, 32'h0, 0, 1'b1);
    wait_idle("trunc_drain");
    check("trunc_cnt", {48'd0, trunc_cnt}, 64'd1);

    // Overrun: second header starts right after the first completes, nothing consumed.
    out_ready = 1'b0;
    drive(32'h45000054, 1'b1, 1'b0, 1'b1);
    drive(32'h1C464000, 1'b1, 1'b0, 1'b0);
    drive(32'h4006B1E6, 1'b1, 1'b0, 1'b0);
    expect_f(0, 32'hABCD, 1'b0);
    expect_f(1, 32'h4, 1'b0);
    expect_f(2, 32'hFF, 1'b1);
    send3(32'h45000054, 32'hABCD8000, 32'h40FF0000, 0, 1'b0);
    check("overrun_cnt", {48'd0, overrun_cnt}, 64'd1);
    out_ready = 1'b1;
    wait_idle("overrun_drain");

    // Rejected write, then a write during SCAN that applies only to the next header.
    cfg(0, 1'b1, 1, 16, 20, 1'b1);
    @(posedge sys_clk);
    #1;
    check("cfg_err_pulse", {63'd0, cfg_err}, 64'd0);
    std_expect(32'h06);
    drive(32'h45000054, 1'b1, 1'b0, 1'b1);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_en = 1'b1; cfg_word = 4'd2; cfg_offset = 5'd0;
    cfg_width = 6'd8;
    drive(32'h1C464000, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;
    check("cfg_scan_err", {63'd0, cfg_err}, 64'd0);
    drive(32'h4006B1E6, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle("cfg_scan_drain");
    std_expect(32'h40);
    send3(32'h45000054, 32'h1C464000, 32'h4006B1E6, 0, 1'b0);
    wait_idle("cfg_next_drain");

    // Valid gaps between words.
    std_expect(32'h40);
    send3(32'h45000054, 32'h1C464000, 32'h4006B1E6, 2, 1'b0);
    wait_idle("stall_drain");

    // Reset mid-SCAN clears state and table.
    drive(32'h45000054, 1'b1, 1'b0, 1'b1);
    reset_n = 1'b0;
    #2;
    check("rst_mid_flags", {60'd0, out_valid, busy, out_last, cfg_err}, 64'd0);
    check("rst_mid_data", {30'd0, out_id, out_data}, 64'd0);
    check("rst_mid_cnts", {32'd0, overrun_cnt, trunc_cnt}, 64'd0);
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    send3(32'h45000054, 32'h1C464000, 32'h4006B1E6, 0, 1'b0);
    check("rst_table_clear", {62'd0, busy, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
